branch_predictor_bht: RTL

Parametrised dynamic branch predictor for the 5-stage RV64 pipeline. It replaces the static prediction signal that feeds IF_ID_prediction and the flush term.
- IF side: combinational lookup (BTB + saturating-counter BHT, optional gshare indexing) gives a predicted direction and target.
- EX side: resolves the branch, raises mispredict and redirect, trains the tables, and repairs the global history.
- Also keeps branch/mispredict statistics counters.

---
 rtl/branch_predictor_bht.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: direct-mapped BTB plus a table of saturating
// direction counters, optionally indexed gshare-style with a global history
// register. Lookup is combinational on the fetch PC; resolution in EX raises
// the flush/redirect, trains both tables, repairs the history and keeps
// branch/mispredict statistics.
module branch_predictor_bht #(
  parameter int PC_W       = 32,
  parameter int IDX_BITS   = 6,
  parameter int CNT_W      = 2,
  parameter int TAG_BITS   = 8,
  parameter int GHR_BITS   = 4,
  parameter int USE_GSHARE = 1
) (
  input  logic                clk,
  input  logic                rst,
  // fetch-side lookup
  input  logic                if_valid,
  input  logic [PC_W-1:0]     if_pc,
  output logic                pred_taken,
  output logic [PC_W-1:0]     pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  // execute-side resolution
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic [PC_W-1:0]     ex_pc,
  input  logic                ex_taken,
  input  logic [PC_W-1:0]     ex_target,
  input  logic                ex_pred_taken,
  input  logic [PC_W-1:0]     ex_pred_target,
  input  logic [GHR_BITS-1:0] ex_ghr,
  output logic                mispredict,
  output logic [PC_W-1:0]     redirect_pc,
  // statistics
  output logic [31:0]         branch_cnt,
  output logic [31:0]         mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Weakly not-taken: MSB clear, every lower bit set.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  // Table state
  logic [CNT_W-1:0]    bht_q        [ENTRIES];
  logic                btb_valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [PC_W-1:0]     btb_target_q [ENTRIES];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         branch_cnt_q, mispred_cnt_q;

  // Fetch-side indexing
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] if_bht_idx;
  logic                if_hit;

  assign if_idx     = if_pc[IDX_BITS+1:2];
  assign if_tag     = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign if_bht_idx = (USE_GSHARE != 0) ? (if_idx ^ IDX_BITS'(ghr_q)) : if_idx;
  assign if_hit     = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);

  // Prediction is forced to "not taken, history 0" while reset is asserted so
  // stale table contents never leak out during the reset cycle.
  assign pred_taken  = !rst && if_hit && bht_q[if_bht_idx][CNT_W-1];
  assign pred_target = pred_taken ? btb_target_q[if_idx] : (if_pc + PC_W'(4));
  assign pred_ghr    = rst ? '0 : ghr_q;

  // Execute-side indexing
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic [IDX_BITS-1:0] ex_bht_idx;
  logic                ex_branch;
  logic [CNT_W-1:0]    ex_cnt_old, ex_cnt_new;

  assign ex_idx     = ex_pc[IDX_BITS+1:2];
  assign ex_tag     = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_bht_idx = (USE_GSHARE != 0) ? (ex_idx ^ IDX_BITS'(ex_ghr)) : ex_idx;
  assign ex_branch  = ex_valid && ex_is_branch;
  assign ex_cnt_old = bht_q[ex_bht_idx];

  // Resolve: flush on wrong direction, wrong taken target, or a non-branch
  // that was predicted taken because it aliased into a BTB entry.
  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end
  end

  assign redirect_pc = (ex_branch && ex_taken) ? ex_target : (ex_pc + PC_W'(4));

  // Saturating counter step for the resolving branch.
  always_comb begin
    ex_cnt_new = ex_cnt_old;
    if (ex_taken) begin
      if (ex_cnt_old != CNT_MAX) ex_cnt_new = ex_cnt_old + CNT_W'(1);
    end else begin
      if (ex_cnt_old != '0) ex_cnt_new = ex_cnt_old - CNT_W'(1);
    end
  end

  // History next state: repair from the carried snapshot wins over the
  // speculative shift of the current fetch.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = ex_is_branch ? ((ex_ghr << 1) | GHR_BITS'(ex_taken)) : ex_ghr;
    end else if (if_valid && if_hit) begin
      ghr_d = (ghr_q << 1) | GHR_BITS'(pred_taken);
    end
  end

  // Direction counters: reset to weakly not-taken, train on every resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else if (ex_branch) begin
      bht_q[ex_bht_idx] <= ex_cnt_new;
    end
  end

  // BTB: install on taken branches, drop entries that made a non-branch look taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (ex_branch && ex_taken) begin
      btb_valid_q[ex_idx]  <= 1'b1;
      btb_tag_q[ex_idx]    <= ex_tag;
      btb_target_q[ex_idx] <= ex_target;
    end else if (ex_valid && !ex_is_branch && ex_pred_taken) begin
      btb_valid_q[ex_idx] <= 1'b0;
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ex_branch && (branch_cnt_q != '1))   branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
